// File: rtl/cry_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
package cry_pkg;

  localparam int                     DEF_PAT_LEN    = 3;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN    = 3'b101;
  localparam int                     DEF_CNT_W      = 8;
  localparam int                     DEF_ALARM_THR  = 4;
  localparam int                     DEF_ALARM_HOLD = 1024;

  // Bits needed to hold the alarm timeout value (at least one).
  function automatic int hold_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/cry_pattern_detector_if.sv
// Data/status bundle of the pattern detector; master drives data, slave reports matches.
interface cry_pattern_detector_if import cry_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             clr;
  logic             in_valid;
  logic             in;
  logic             out;
  logic             alarm;
  logic [CNT_W-1:0] match_cnt;

  modport master (output clr, in_valid, in, input  out, alarm, match_cnt);
  modport slave  (input  clr, in_valid, in, output out, alarm, match_cnt);

endinterface

// File: rtl/cry_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module cry_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_sat
);

  logic [WIDTH-1:0] r_cnt;

  assign o_sat = &r_cnt;
  assign o_cnt = r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cry_pattern_detector.sv
// Serial bit-pattern detector with match pulse, saturating match counter and sticky alarm.
// Optional alarm auto-clear after ALARM_HOLD quiet cycles: define CRY_ALARM_TIMEOUT_EN.
module cry_pattern_detector import cry_pkg::*; #(
  parameter int                 PAT_LEN    = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN    = DEF_PATTERN,
  parameter bit                 OVERLAP    = 1'b1,
  parameter int                 CNT_W      = DEF_CNT_W,
  parameter int                 ALARM_THR  = DEF_ALARM_THR,
  parameter int                 ALARM_HOLD = DEF_ALARM_HOLD
) (
  input logic                   clk,
  input logic                   rstn,
  cry_pattern_detector_if.slave bus
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               r_out;
  logic               r_alarm;
  logic               w_accept;
  logic               w_match;
  logic               w_alarm_set;
  logic               w_timeout;
  logic               w_cnt_clr;
  logic               w_cnt_sat;
  logic [CNT_W-1:0]   w_cnt;

  // A clear on the same edge wins and discards the offered bit.
  assign w_accept   = bus.in_valid && !bus.clr;
  assign w_hist_nxt = {r_hist[PAT_LEN-2:0], bus.in};
  assign w_fill_nxt = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
  assign w_match    = w_accept && (w_hist_nxt == PATTERN) && (w_fill_nxt == FILL_FULL);

  // Saturated counter already counts as having passed the threshold.
  assign w_alarm_set = w_match &&
                       (w_cnt_sat || (({1'b0, w_cnt} + (CNT_W+1)'(1)) >= (CNT_W+1)'(ALARM_THR)));
  assign w_cnt_clr   = bus.clr || w_timeout;

  cry_sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (w_cnt_clr),
    .i_inc (w_match),
    .o_cnt (w_cnt),
    .o_sat (w_cnt_sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
      r_alarm <= 1'b0;
    end else if (bus.clr) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_out <= w_match;
      if (w_accept) begin
        r_hist <= w_hist_nxt;
        r_fill <= (w_match && !OVERLAP) ? '0 : w_fill_nxt;
      end
      if (w_alarm_set) begin
        r_alarm <= 1'b1;
      end else if (w_timeout) begin
        r_alarm <= 1'b0;
      end
    end
  end

`ifdef CRY_ALARM_TIMEOUT_EN
  localparam int HOLD_W = hold_width(ALARM_HOLD);

  logic [HOLD_W-1:0] r_hold;

  // Expires on the edge that would take the hold count from 1 to 0.
  assign w_timeout = r_alarm && !w_match && (r_hold <= HOLD_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold <= '0;
    end else if (bus.clr) begin
      r_hold <= '0;
    end else if (w_match) begin
      r_hold <= HOLD_W'(ALARM_HOLD);
    end else if (r_alarm && (r_hold != '0)) begin
      r_hold <= r_hold - HOLD_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign bus.out       = r_out;
  assign bus.alarm     = r_alarm;
  assign bus.match_cnt = w_cnt;

endmodule

// File: doc/cry_pattern_detector.md
CRY_PATTERN_DETECTOR -- requirements
Module: cry_pattern_detector

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b101, PAT_LEN bits wide: target sequence; bit PAT_LEN-1 is the oldest bit, bit 0 the newest.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 Parameter ALARM_THR, default 4: number of matches that raises alarm, legal range 1..2^CNT_W-1.
REQ-006 Parameter ALARM_HOLD, default 1024: alarm timeout in cycles; used only under CRY_ALARM_TIMEOUT_EN.
REQ-007 clk  input  1  clock; all state changes on the rising edge.
REQ-008 rstn  input  1  reset; asynchronous assert, active-low.
REQ-009 clr  input  1  synchronous clear of history, counter and alarm.
REQ-010 in_valid  input  1  qualifies in; in is sampled only when in_valid=1.
REQ-011 in  input  1  serial data bit.
REQ-012 out  output  1  one-cycle match pulse.
REQ-013 alarm  output  1  sticky alarm flag.
REQ-014 match_cnt  output  CNT_W  matches since last reset or clear, saturating.

Function
REQ-015 The block shall hold a PAT_LEN-bit history register of accepted bits and a fill counter saturating at PAT_LEN.
REQ-016 Each accepted bit shall shift into history bit 0 and increment the fill counter; cycles with in_valid=0 shall leave all state unchanged.
REQ-017 A match shall occur when an accepted bit makes history==PATTERN with fill==PAT_LEN after the shift.
REQ-018 out shall be registered: high for exactly one cycle, in the cycle after the edge that samples the completing bit (latency 1), and low otherwise.
REQ-019 OVERLAP=1: history and fill are kept after a match, so 10101 with PATTERN 101 produces 2 matches.
REQ-020 OVERLAP=0: fill resets to 0 on a match, so the next match needs PAT_LEN new accepted bits, and 10101 produces 1 match.
REQ-021 match_cnt shall increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-022 alarm shall set on the edge where match_cnt reaches ALARM_THR, or would reach it if not saturated, and stay set until clr or reset.
REQ-023 clr=1 shall zero history, fill, match_cnt, out and alarm on that edge; clr has priority over a simultaneous in_valid, and that bit is discarded.
REQ-024 A match and the alarm set shall take effect on the same edge, so alarm rises in the same cycle as the pulse on out.

Reset
REQ-025 rstn=0 shall immediately force history=0, fill=0, out=0, alarm=0 and match_cnt=0, independent of clk.
REQ-026 Reset deassertion mid-sequence shall restart detection from an empty history; no partial pattern survives reset.

Configuration
REQ-027 With CRY_ALARM_TIMEOUT_EN defined, a hold counter shall reload to ALARM_HOLD on every match and decrement each cycle while alarm=1; at 0 it shall clear alarm and match_cnt.
REQ-028 Without CRY_ALARM_TIMEOUT_EN, no hold counter shall exist and alarm clears only by clr or rstn.

Structure
REQ-029 Package cry_pkg shall hold the default constants for PAT_LEN, PATTERN, CNT_W, ALARM_THR and ALARM_HOLD, plus a function returning the hold counter width.
REQ-030 A sub-module cry_sat_counter (parametrised width, inc, clr, saturation) shall implement match_cnt; it is reusable for the hold counter.

Verification
REQ-031 Default parameters, in_valid=1, stream 1,0,1 -> out=1 in the cycle after the third bit; match_cnt=1.
REQ-032 Stream 1,0,1,0,1 with OVERLAP=1 -> 2 pulses, match_cnt=2; with OVERLAP=0 -> 1 pulse, match_cnt=1.
REQ-033 Stream 1,0,x,1 with in_valid=0 during x -> 1 match; history is unaffected by the invalid cycle.
REQ-034 Four matches with ALARM_THR=4 -> alarm rises with the 4th pulse; clr=1 with in_valid=1 -> alarm=0, match_cnt=0, no match from that bit.
REQ-035 CNT_W=2, 5 matches -> match_cnt holds at 3; rstn pulsed low between clock edges -> all outputs 0 immediately.
REQ-036 CRY_ALARM_TIMEOUT_EN with ALARM_HOLD=8: alarm set, then no matches -> alarm and match_cnt are 0 eight cycles after the last match.
